// File: rtl/mmio_timer_bank.sv
// Bank of N_CH reload timers on the data bus with a shared prescaler.
// Per-channel enable/irq_en/status/one_shot; pending bits merge into irqout.
module mmio_timer_bank #(
  parameter int          N_CH     = 2,
  parameter int          WIDTH    = 32,
  parameter int          PRESCALE = 1,
  parameter logic [31:0] BASE     = 32'h4000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rd,
  input  logic            wr,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            en,
  output logic [N_CH-1:0] irq_vec,
  output logic            irqout
);

  localparam int PW = 17;

  logic [WIDTH-1:0] th_q [N_CH];
  logic [WIDTH-1:0] th_d [N_CH];
  logic [WIDTH-1:0] tl_q [N_CH];
  logic [WIDTH-1:0] tl_d [N_CH];
  logic [N_CH-1:0]  ena_q, ena_d;
  logic [N_CH-1:0]  ie_q, ie_d;
  logic [N_CH-1:0]  st_q, st_d;
  logic [N_CH-1:0]  os_q, os_d;
  logic [PW-1:0]    pre_q, pre_d;

  logic [29:0] woff;
  logic [2:0]  ch_sel;
  logic [1:0]  reg_sel;
  logic        ch_hit;
  logic        pend_hit;
  logic        tick;
  logic        unused_bits;

  assign unused_bits = ^{addr[1:0], wdata};

  // Word offset from BASE; channel blocks are 4 words, last word is a hole.
  always_comb begin
    woff     = addr[31:2] - BASE[31:2];
    ch_sel   = woff[4:2];
    reg_sel  = woff[1:0];
    ch_hit   = (woff[29:2] < 28'(N_CH)) && (reg_sel != 2'd3);
    pend_hit = (woff == 30'h40);
  end

  assign en      = ch_hit | pend_hit;
  assign irq_vec = st_q & ie_q;
  assign irqout  = |irq_vec;

  always_comb begin
    logic sel;
    logic ov;
    logic w1c;
    sel   = 1'b0;
    ov    = 1'b0;
    w1c   = 1'b0;
    tick  = (|ena_q) && (pre_q == PW'(PRESCALE - 1));
    pre_d = (!(|ena_q) || tick) ? '0 : pre_q + 1'b1;
    ena_d = ena_q;
    ie_d  = ie_q;
    os_d  = os_q;
    st_d  = st_q;
    for (int c = 0; c < N_CH; c++) begin
      th_d[c] = th_q[c];
      tl_d[c] = tl_q[c];
      sel = ch_hit && (ch_sel == 3'(c));
      ov  = tick && ena_q[c] && (&tl_q[c]);
      w1c = (wr && pend_hit && wdata[c])
          | (wr && sel && reg_sel == 2'd2 && wdata[2]);
      if (tick && ena_q[c])
        tl_d[c] = ov ? th_q[c] : tl_q[c] + 1'b1;
      if (ov && os_q[c])
        ena_d[c] = 1'b0;
      // A hardware set always survives a same-edge clear.
      st_d[c] = ov | (st_q[c] & ~w1c);
      if (wr && sel) begin
        unique case (1'b1)
          reg_sel == 2'd0: th_d[c] = wdata[WIDTH-1:0];
          reg_sel == 2'd1: tl_d[c] = wdata[WIDTH-1:0];
          default: begin
            ena_d[c] = wdata[0];
            ie_d[c]  = wdata[1];
            os_d[c]  = wdata[3];
          end
        endcase
      end
    end
  end

  always_comb begin
    logic [31:0] rsel;
    rsel = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_hit && ch_sel == 3'(c)) begin
        unique case (1'b1)
          reg_sel == 2'd0: rsel = 32'(th_q[c]);
          reg_sel == 2'd1: rsel = 32'(tl_q[c]);
          default:
            rsel = {28'b0, os_q[c], st_q[c], ie_q[c], ena_q[c]};
        endcase
      end
    end
    if (pend_hit)
      rsel = 32'(irq_vec);
    rdata = (rd && en) ? rsel : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < N_CH; c++) begin
        th_q[c] <= '0;
        tl_q[c] <= '0;
      end
      ena_q <= '0;
      ie_q  <= '0;
      st_q  <= '0;
      os_q  <= '0;
      pre_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        th_q[c] <= th_d[c];
        tl_q[c] <= tl_d[c];
      end
      ena_q <= ena_d;
      ie_q  <= ie_d;
      st_q  <= st_d;
      os_q  <= os_d;
      pre_q <= pre_d;
    end
  end

endmodule

// File: tb/tb_mmio_timer_bank.sv
// Bench for mmio_timer_bank: reference model on the PRESCALE=1 instance,
// directed literal checks on both it and a PRESCALE=4 instance.
module tb_mmio_timer_bank;

  localparam logic [31:0] B = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, rdata4;
  logic        en, en4;
  logic [1:0]  irq_vec, irq4;
  logic        irqout, irqout4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mmio_timer_bank #(.N_CH(2), .WIDTH(8), .PRESCALE(1), .BASE(B)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .en(en), .irq_vec(irq_vec),
    .irqout(irqout)
  );

  mmio_timer_bank #(.N_CH(2), .WIDTH(8), .PRESCALE(4), .BASE(B)) dut4 (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata4), .en(en4), .irq_vec(irq4),
    .irqout(irqout4)
  );

  // Reference model: two 8-bit channels ticking every cycle when enabled.
  int       m_th [2];
  int       m_tl [2];
  bit [1:0] m_en, m_ie, m_st, m_os;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_th <= '{0, 0};
      m_tl <= '{0, 0};
      m_en <= '0;
      m_ie <= '0;
      m_st <= '0;
      m_os <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        automatic bit          ov  = m_en[c] && (m_tl[c] == 255);
        automatic int          tln = m_tl[c];
        automatic int          thn = m_th[c];
        automatic bit          enn = m_en[c];
        automatic bit          ien = m_ie[c];
        automatic bit          osn = m_os[c];
        automatic bit          clr = 1'b0;
        automatic logic [31:0] off = addr - B;
        if (m_en[c]) tln = ov ? m_th[c] : (m_tl[c] + 1) % 256;
        if (ov && m_os[c]) enn = 1'b0;
        if (wr) begin
          if (off == 32'h100) clr = wdata[c];
          else if (off / 16 == c && off < 32) begin
            case ((off % 16) / 4)
              0: thn = int'(wdata & 32'hFF);
              1: tln = int'(wdata & 32'hFF);
              2: begin
                enn = wdata[0];
                ien = wdata[1];
                osn = wdata[3];
                clr = wdata[2];
              end
              default: ;
            endcase
          end
        end
        m_th[c] <= thn;
        m_tl[c] <= tln;
        m_en[c] <= enn;
        m_ie[c] <= ien;
        m_os[c] <= osn;
        m_st[c] <= ov || (m_st[c] && !clr);
      end
    end
  end

  function automatic logic [32:0] m_read(logic [31:0] a);
    logic [31:0] off;
    int c;
    off = a - B;
    if (off[31:2] == 30'h40) return {1'b1, 30'b0, m_st & m_ie};
    if (off < 32 && (off % 16) < 12) begin
      c = int'(off / 16);
      case ((off % 16) / 4)
        0: return {1'b1, 32'(m_th[c])};
        1: return {1'b1, 32'(m_tl[c])};
        default:
          return {1'b1, 28'b0, m_os[c], m_st[c], m_ie[c], m_en[c]};
      endcase
    end
    return '0;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      automatic logic [32:0] r = m_read(addr);
      check("mdl_irq_vec", irq_vec, m_st & m_ie);
      check("mdl_irqout", irqout, |(m_st & m_ie));
      check("mdl_en", en, r[32]);
      check("mdl_rdata", rdata, rd ? r[31:0] : 32'h0);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic write(logic [31:0] a, logic [31:0] d);
    step();
    rd = 1'b0; wr = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic rdchk(string nm, logic [31:0] a, logic ee,
                       logic [31:0] exp);
    step();
    wr = 1'b0; rd = 1'b1; addr = a;
    #1;
    check({nm, "_en"}, en, ee);
    check(nm, rdata, exp);
  endtask

  task automatic rdchk4(string nm, logic [31:0] a, logic [31:0] exp);
    step();
    wr = 1'b0; rd = 1'b1; addr = a;
    #1;
    check(nm, rdata4, exp);
  endtask

  initial begin
    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    repeat (2) step();
    rdchk("rst0_tl0", B + 32'h4, 1'b1, 32'h0);
    check("rst0_irqout", irqout, 32'h0);
    reset = 1'b1;

    // Auto-reload through overflow
    write(B + 32'h0, 32'hF0);
    write(B + 32'h4, 32'hFD);
    write(B + 32'h8, 32'h3);
    rdchk("ar_fd", B + 32'h4, 1'b1, 32'hFD);
    rdchk("ar_fe", B + 32'h4, 1'b1, 32'hFE);
    rdchk("ar_ff", B + 32'h4, 1'b1, 32'hFF);
    check("ar_irq_before", irqout, 32'h0);
    rdchk("ar_f0", B + 32'h4, 1'b1, 32'hF0);
    check("ar_irq_after", irqout, 32'h1);
    rdchk("ar_f1", B + 32'h4, 1'b1, 32'hF1);
    rdchk("ar_f2", B + 32'h4, 1'b1, 32'hF2);
    check("mdl_pin_tl0", 32'(m_tl[0]), 32'hF2);
    write(B + 32'h8, 32'h6);
    rdchk("pend_clr0", B + 32'h100, 1'b1, 32'h0);

    // One-shot on channel 1
    write(B + 32'h10, 32'h10);
    write(B + 32'h14, 32'hFF);
    write(B + 32'h18, 32'hB);
    rdchk("os_ff", B + 32'h14, 1'b1, 32'hFF);
    rdchk("os_reload", B + 32'h14, 1'b1, 32'h10);
    rdchk("os_tcon", B + 32'h18, 1'b1, 32'hE);
    check("os_irq_vec", irq_vec, 32'h2);
    rdchk("os_hold", B + 32'h14, 1'b1, 32'h10);
    rdchk("os_pend", B + 32'h100, 1'b1, 32'h2);
    write(B + 32'h100, 32'h2);
    rdchk("os_pend_clr", B + 32'h100, 1'b1, 32'h0);

    // W1C racing a new overflow
    write(B + 32'h4, 32'hFF);
    write(B + 32'h8, 32'h3);
    write(B + 32'h4, 32'hFF);
    check("race_pin_st", 32'(m_st), 32'h1);
    write(B + 32'h100, 32'h1);
    check("race_irq_kept", irqout, 32'h1);
    rdchk("race_tcon", B + 32'h8, 1'b1, 32'h7);
    write(B + 32'h100, 32'h1);
    check("race_irq_clr", irqout, 32'h0);

    // Asynchronous reset mid-count with an interrupt pending
    write(B + 32'h4, 32'hFF);
    step();
    step();
    check("rst_pre_irq", irqout, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_irqout", irqout, 32'h0);
    check("rst_irq_vec", irq_vec, 32'h0);
    check("rst_irqout4", irqout4, 32'h0);
    rd = 1'b1;
    addr = B + 32'h4;  #1; check("rst_tl0", rdata, 32'h0);
    addr = B + 32'h0;  #1; check("rst_th0", rdata, 32'h0);
    addr = B + 32'h8;  #1; check("rst_tcon0", rdata, 32'h0);
    addr = B + 32'h14; #1; check("rst_tl1", rdata, 32'h0);
    step();
    reset = 1'b1;

    // Decode holes
    rdchk("dec_hole0c", B + 32'h0C, 1'b0, 32'h0);
    rdchk("dec_ch2", B + 32'h20, 1'b0, 32'h0);
    rdchk("dec_104", B + 32'h104, 1'b0, 32'h0);
    rdchk("dec_pend", B + 32'h100, 1'b1, 32'h0);

    // Prescaler on the PRESCALE=4 instance
    write(B + 32'h8, 32'h1);
    rdchk4("ps_c0", B + 32'h4, 32'h0);
    repeat (3) step();
    rdchk4("ps_c4", B + 32'h4, 32'h1);
    repeat (3) step();
    rdchk4("ps_c8", B + 32'h4, 32'h2);
    repeat (2) step();
    write(B + 32'h4, 32'h55);
    rdchk4("ps_sw_wins", B + 32'h4, 32'h55);
    repeat (3) step();
    rdchk4("ps_next", B + 32'h4, 32'h56);

    step();
    rd = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
